// File: rtl/pwm_servo_bank_pkg.sv
// +----------------------------------------------------------------------+
// | pwm_servo_bank_pkg                                                   |
// | Register word offsets and bit positions for the PWM servo bank.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package pwm_servo_bank_pkg;

  // Word offsets, i.e. PADDR[7:2]
  localparam logic [5:0] c_ofs_ctrl     = 6'h00;
  localparam logic [5:0] c_ofs_period   = 6'h01;
  localparam logic [5:0] c_ofs_prescale = 6'h02;
  localparam logic [5:0] c_ofs_status   = 6'h03;
  localparam logic [5:0] c_ofs_duty0    = 6'h04;

  localparam int c_ctrl_en_bit     = 0;
  localparam int c_ctrl_ie_bit     = 1;
  localparam int c_ctrl_chen_lsb   = 8;
  localparam int c_status_wrap_bit = 0;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_CTRL,
    SEL_PERIOD,
    SEL_PRESCALE,
    SEL_STATUS,
    SEL_DUTY
  } reg_sel_e;

endpackage

`default_nettype wire

// File: rtl/pwm_bank_channel.sv
// +----------------------------------------------------------------------+
// | pwm_bank_channel                                                     |
// | One PWM channel: shadow duty register, comparator and output flop.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module pwm_bank_channel #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_duty,
  input  logic [CNT_W-1:0] i_cnt,
  output logic             o_pwm
);

  logic [CNT_W-1:0] r_duty_act;
  logic             r_pwm;

  // The compare uses the shadow value still in force, so a load at wrap
  // only affects the period that starts after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_duty_act <= '0;
      r_pwm      <= 1'b0;
    end else begin
      if (i_load) begin
        r_duty_act <= i_duty;
      end
      r_pwm <= i_en & (i_cnt < r_duty_act);
    end
  end

  assign o_pwm = r_pwm;

endmodule

`default_nettype wire

// File: rtl/pwm_servo_bank.sv
// +----------------------------------------------------------------------+
// | pwm_servo_bank                                                       |
// | APB3 bank of PWM channels with shared prescaler and period counter.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module pwm_servo_bank #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int PRE_W  = 8
) (
  input  logic              SYSCLK,
  input  logic              NSYSRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [7:0]        PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [NUM_CH-1:0] PWM,
  output logic              IRQ
);

  import pwm_servo_bank_pkg::*;

  logic              r_en;
  logic              r_ie;
  logic [NUM_CH-1:0] r_ch_en;
  logic [CNT_W-1:0]  r_period;
  logic [PRE_W-1:0]  r_prescale;
  logic              r_wrap;
  logic [CNT_W-1:0]  r_duty [NUM_CH];
  logic [CNT_W-1:0]  r_period_act;
  logic [PRE_W-1:0]  r_pre;
  logic [CNT_W-1:0]  r_cnt;

  logic [5:0]        w_widx;
  reg_sel_e          w_sel;
  logic [NUM_CH-1:0] w_duty_hit;
  logic              w_access;
  logic              w_wr;
  logic              w_wr_ctrl;
  logic              w_wr_period;
  logic              w_wr_prescale;
  logic              w_wr_status;
  logic              w_wr_duty;
  logic              w_en_nxt;
  logic [NUM_CH-1:0] w_ch_en_nxt;
  logic              w_en_rise;
  logic              w_run;
  logic              w_tick;
  logic              w_wrap;
  logic              w_load;
  logic              w_unused;

  assign w_widx   = PADDR[7:2];
  assign w_access = PSEL & PENABLE;
  assign w_unused = ^{PADDR[1:0], PWDATA};

  always_comb begin
    w_sel      = SEL_NONE;
    w_duty_hit = '0;
    case (w_widx)
      c_ofs_ctrl:     w_sel = SEL_CTRL;
      c_ofs_period:   w_sel = SEL_PERIOD;
      c_ofs_prescale: w_sel = SEL_PRESCALE;
      c_ofs_status:   w_sel = SEL_STATUS;
      default:        w_sel = SEL_NONE;
    endcase
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_widx == c_ofs_duty0 + 6'(i)) begin
        w_sel         = SEL_DUTY;
        w_duty_hit[i] = 1'b1;
      end
    end
  end

  assign w_wr          = w_access & PWRITE & (w_sel != SEL_NONE);
  assign w_wr_ctrl     = w_wr & (w_sel == SEL_CTRL);
  assign w_wr_period   = w_wr & (w_sel == SEL_PERIOD);
  assign w_wr_prescale = w_wr & (w_sel == SEL_PRESCALE);
  assign w_wr_status   = w_wr & (w_sel == SEL_STATUS);
  assign w_wr_duty     = w_wr & (w_sel == SEL_DUTY);

  assign PREADY  = 1'b1;
  assign PSLVERR = w_access & (w_sel == SEL_NONE);

  always_comb begin
    PRDATA = '0;
    if (PSEL && !PWRITE) begin
      case (w_sel)
        SEL_CTRL: begin
          PRDATA[c_ctrl_en_bit]                 = r_en;
          PRDATA[c_ctrl_ie_bit]                 = r_ie;
          PRDATA[c_ctrl_chen_lsb +: NUM_CH]     = r_ch_en;
        end
        SEL_PERIOD:   PRDATA[CNT_W-1:0]         = r_period;
        SEL_PRESCALE: PRDATA[PRE_W-1:0]         = r_prescale;
        SEL_STATUS:   PRDATA[c_status_wrap_bit] = r_wrap;
        SEL_DUTY: begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (w_duty_hit[i]) begin
              PRDATA[CNT_W-1:0] = r_duty[i];
            end
          end
        end
        default: PRDATA = '0;
      endcase
    end
  end

  // Disables act through the *next* control value so outputs drop on the
  // cycle right after the write; enables wait for the registered EN.
  assign w_en_nxt    = w_wr_ctrl ? PWDATA[c_ctrl_en_bit] : r_en;
  assign w_ch_en_nxt = w_wr_ctrl ? PWDATA[c_ctrl_chen_lsb +: NUM_CH] : r_ch_en;
  assign w_en_rise   = w_en_nxt & ~r_en;
  assign w_run       = r_en & w_en_nxt;
  assign w_tick      = w_run & (r_pre >= r_prescale);
  assign w_wrap      = w_tick & (r_cnt == r_period_act);
  assign w_load      = w_wrap | w_en_rise;

  always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
    if (!NSYSRESET) begin
      r_en         <= 1'b0;
      r_ie         <= 1'b0;
      r_ch_en      <= '0;
      r_period     <= '0;
      r_prescale   <= '0;
      r_wrap       <= 1'b0;
      r_period_act <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_duty[i] <= '0;
      end
    end else begin
      if (w_wr_ctrl) begin
        r_en    <= w_en_nxt;
        r_ie    <= PWDATA[c_ctrl_ie_bit];
        r_ch_en <= w_ch_en_nxt;
      end
      if (w_wr_period) begin
        r_period <= PWDATA[CNT_W-1:0];
      end
      if (w_wr_prescale) begin
        r_prescale <= PWDATA[PRE_W-1:0];
      end
      // A wrap wins over a coincident write-1-to-clear
      if (w_wrap) begin
        r_wrap <= 1'b1;
      end else if (w_wr_status && PWDATA[c_status_wrap_bit]) begin
        r_wrap <= 1'b0;
      end
      if (w_load) begin
        r_period_act <= r_period;
      end
      if (w_wr_duty) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (w_duty_hit[i]) begin
            r_duty[i] <= PWDATA[CNT_W-1:0];
          end
        end
      end
    end
  end

  always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
    if (!NSYSRESET) begin
      r_pre <= '0;
      r_cnt <= '0;
    end else if (!w_run) begin
      r_pre <= '0;
      r_cnt <= '0;
    end else if (w_tick) begin
      r_pre <= '0;
      r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  assign IRQ = r_wrap & r_ie;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    pwm_bank_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk    (SYSCLK),
      .rst_n  (NSYSRESET),
      .i_load (w_load),
      .i_en   (w_run & r_ch_en[gi] & w_ch_en_nxt[gi]),
      .i_duty (r_duty[gi]),
      .i_cnt  (r_cnt),
      .o_pwm  (PWM[gi])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_pwm_servo_bank.sv
// +----------------------------------------------------------------------+
// | tb_pwm_servo_bank                                                    |
// | Scoreboard bench for pwm_servo_bank: APB reads and PWM/IRQ stream.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_pwm_servo_bank;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;
  localparam int PRE_W  = 8;

  logic              SYSCLK    = 1'b0;
  logic              NSYSRESET = 1'b1;
  logic              PSEL      = 1'b0;
  logic              PENABLE   = 1'b0;
  logic              PWRITE    = 1'b0;
  logic [7:0]        PADDR     = '0;
  logic [31:0]       PWDATA    = '0;
  logic [31:0]       PRDATA;
  logic              PREADY;
  logic              PSLVERR;
  logic [NUM_CH-1:0] PWM;
  logic              IRQ;

  int n_checks = 0;
  int n_errors = 0;
  int mon_idx  = 0;

  typedef struct packed {
    logic [NUM_CH-1:0] pwm;
    logic              irq;
  } mon_t;

  mon_t        mon_q [$];
  logic [32:0] rd_q  [$];

  always #5 SYSCLK = ~SYSCLK;

  pwm_servo_bank #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W),
    .PRE_W  (PRE_W)
  ) dut (
    .SYSCLK    (SYSCLK),
    .NSYSRESET (NSYSRESET),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR),
    .PWM       (PWM),
    .IRQ       (IRQ)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%08h exp 0x%08h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [NUM_CH-1:0] p, input logic i);
    mon_t e;
    e.pwm = p;
    e.irq = i;
    mon_q.push_back(e);
  endtask

  // Output monitor: one expected entry per falling edge while any are queued
  always @(negedge SYSCLK) begin
    mon_t e;
    if (mon_q.size() > 0) begin
      e = mon_q.pop_front();
      check_val($sformatf("pwm[%0d]", mon_idx), 32'(PWM), 32'(e.pwm));
      check_val($sformatf("irq[%0d]", mon_idx), 32'(IRQ), 32'(e.irq));
      mon_idx++;
    end
  end

  task automatic drain();
    while (mon_q.size() != 0) @(posedge SYSCLK);
    #1;
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d, input logic exp_err);
    PSEL = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = d; PENABLE = 1'b0;
    @(posedge SYSCLK); #1;
    PENABLE = 1'b1;
    @(negedge SYSCLK);
    check_val($sformatf("wr_err@%02h", a), 32'(PSLVERR), 32'(exp_err));
    @(posedge SYSCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, input logic [31:0] exp_d, input logic exp_err);
    logic [32:0] e;
    rd_q.push_back({exp_err, exp_d});
    PSEL = 1'b1; PWRITE = 1'b0; PADDR = a; PENABLE = 1'b0;
    @(posedge SYSCLK); #1;
    PENABLE = 1'b1;
    @(negedge SYSCLK);
    e = rd_q.pop_front();
    check_val($sformatf("rd@%02h", a), PRDATA, e[31:0]);
    check_val($sformatf("rd_err@%02h", a), 32'(PSLVERR), 32'(e[32]));
    @(posedge SYSCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values while reset is held
    #1 NSYSRESET = 1'b0;
    #1;
    check_val("rst_pwm", 32'(PWM), 32'h0);
    check_val("rst_irq", 32'(IRQ), 32'h0);
    check_val("rst_prdata", PRDATA, 32'h0);
    check_val("rst_pslverr", 32'(PSLVERR), 32'h0);
    check_val("rst_pready", 32'(PREADY), 32'h1);
    repeat (3) @(posedge SYSCLK);
    @(negedge SYSCLK) NSYSRESET = 1'b1;
    @(posedge SYSCLK); #1;

    apb_read(8'h00, 32'h0, 1'b0);
    apb_read(8'h04, 32'h0, 1'b0);
    apb_read(8'h08, 32'h0, 1'b0);
    apb_read(8'h0C, 32'h0, 1'b0);
    apb_read(8'h10, 32'h0, 1'b0);

    // Register access and unmapped offsets
    apb_write(8'h04, 32'h0000_1234, 1'b0);
    apb_read (8'h04, 32'h0000_1234, 1'b0);
    apb_read (8'h40, 32'h0, 1'b1);
    apb_write(8'h40, 32'hFFFF_FFFF, 1'b1);
    apb_write(8'h20, 32'hFFFF_FFFF, 1'b1);
    apb_read (8'h04, 32'h0000_1234, 1'b0);
    apb_read (8'h00, 32'h0, 1'b0);
    apb_read (8'h20, 32'h0, 1'b1);
    apb_write(8'h08, 32'h0000_005A, 1'b0);
    apb_read (8'h08, 32'h0000_005A, 1'b0);
    apb_write(8'h1C, 32'h0000_BEEF, 1'b0);
    apb_read (8'h1F, 32'h0000_BEEF, 1'b0);

    // Basic waveform, then a duty change in the middle of a period
    apb_write(8'h08, 32'd0, 1'b0);
    apb_write(8'h04, 32'd9, 1'b0);
    apb_write(8'h10, 32'd3, 1'b0);
    apb_write(8'h00, 32'h0000_0101, 1'b0);
    for (int k = 0; k < 40; k++) begin
      int c;
      int d;
      c = (k - 1) % 10;
      d = (k <= 20) ? 3 : 7;
      if (k == 0) push_exp('0, 1'b0);
      else        push_exp({3'b000, (c < d)}, 1'b0);
    end
    repeat (13) @(posedge SYSCLK);
    #1;
    apb_write(8'h10, 32'd7, 1'b0);
    drain();
    apb_read(8'h00, 32'h0000_0101, 1'b0);
    apb_read(8'h0C, 32'h0000_0001, 1'b0);

    // EN cleared: outputs low next cycle, registers retained
    apb_write(8'h00, 32'h0, 1'b0);
    repeat (3) push_exp('0, 1'b0);
    drain();
    apb_read(8'h04, 32'd9, 1'b0);
    apb_read(8'h10, 32'd7, 1'b0);

    // Duty above period and duty zero
    apb_write(8'h14, 32'd10, 1'b0);
    apb_write(8'h18, 32'd0, 1'b0);
    apb_write(8'h00, 32'h0000_0601, 1'b0);
    push_exp('0, 1'b0);
    repeat (24) push_exp(4'b0010, 1'b0);
    drain();
    apb_write(8'h00, 32'h0000_0401, 1'b0);
    repeat (3) push_exp('0, 1'b0);
    drain();

    // WRAP / IRQ with prescaler, including W1C coincident with a wrap
    apb_write(8'h00, 32'h0, 1'b0);
    apb_write(8'h0C, 32'h1, 1'b0);
    apb_read (8'h0C, 32'h0, 1'b0);
    apb_write(8'h08, 32'd4, 1'b0);
    apb_write(8'h04, 32'd1, 1'b0);
    apb_write(8'h00, 32'h0000_0003, 1'b0);
    for (int k = 0; k < 26; k++) begin
      push_exp('0, ((k >= 10) && (k <= 12)) || (k >= 20));
    end
    repeat (11) @(posedge SYSCLK);
    #1;
    apb_write(8'h0C, 32'h1, 1'b0);
    repeat (5) @(posedge SYSCLK);
    #1;
    apb_write(8'h0C, 32'h1, 1'b0);
    drain();

    // Asynchronous reset in mid-period
    apb_write(8'h00, 32'h0, 1'b0);
    apb_write(8'h08, 32'd0, 1'b0);
    apb_write(8'h04, 32'd9, 1'b0);
    apb_write(8'h10, 32'd5, 1'b0);
    apb_write(8'h00, 32'h0000_0103, 1'b0);
    repeat (2) @(posedge SYSCLK);
    #2;
    check_val("pre_rst_pwm", 32'(PWM), 32'h1);
    NSYSRESET = 1'b0;
    #1;
    check_val("async_rst_pwm", 32'(PWM), 32'h0);
    check_val("async_rst_irq", 32'(IRQ), 32'h0);
    @(negedge SYSCLK) NSYSRESET = 1'b1;
    @(posedge SYSCLK); #1;
    for (int a = 0; a < 8; a++) begin
      apb_read(8'(a * 4), 32'h0, 1'b0);
    end
    repeat (12) push_exp('0, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
